// File: rtl/regfile_pkg.sv
// Shared widths and control encodings for the GPR file and its read ports.
package regfile_pkg;

   localparam int unsigned REG_ADDR_WIDTH = 5;
   localparam int unsigned REG_DATA_WIDTH = 32;
   localparam int unsigned REG_NUM        = 32;

   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG_ADDR = 5'd0;

   localparam logic READ_EN   = 1'b1;
   localparam logic READ_DIS  = 1'b0;
   localparam logic WRITE_EN  = 1'b1;
   localparam logic WRITE_DIS = 1'b0;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: reset/enable/$0 gating, write-first bypass, then storage.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = REG_DATA_WIDTH,
   parameter int unsigned ADDR_W   = REG_ADDR_WIDTH,
   parameter int unsigned NUM_REGS = REG_NUM
) (
   input  logic                             rst_n,
   input  logic                             r_en,
   input  logic [ADDR_W-1:0]                r_addr,
   input  logic                             w_reg_en,
   input  logic [ADDR_W-1:0]                w_reg_addr,
   input  logic [DATA_W-1:0]                w_reg_data,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]  mem,
   output logic [DATA_W-1:0]                r_data
);

   always_comb begin
      r_data = '0;
      if (!rst_n) begin
         r_data = '0;
      end else if (r_en == READ_DIS) begin
         r_data = '0;
      end else if (r_addr == ZERO_REG_ADDR) begin
         r_data = '0;
      end else if ((w_reg_en == WRITE_EN) && (w_reg_addr == r_addr)) begin
         // Bypass lets id consume a wb result in the same cycle without a stall.
         r_data = w_reg_data;
      end else begin
         r_data = mem[r_addr];
      end
   end

endmodule

// File: rtl/regfile.sv
// 32 x 32 GPR file: one synchronous write port, two bypassed combinational read ports.
module regfile
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = REG_DATA_WIDTH,
   parameter int unsigned ADDR_W   = REG_ADDR_WIDTH,
   parameter int unsigned NUM_REGS = REG_NUM
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              w_reg_en,
   input  logic [ADDR_W-1:0] w_reg_addr,
   input  logic [DATA_W-1:0] w_reg_data,
   input  logic              r1_en,
   input  logic [ADDR_W-1:0] r1_addr,
   output logic [DATA_W-1:0] r1_data,
   input  logic              r2_en,
   input  logic [ADDR_W-1:0] r2_addr,
   output logic [DATA_W-1:0] r2_data
);

   logic [NUM_REGS-1:0][DATA_W-1:0] mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '0;
      end else if ((w_reg_en == WRITE_EN) && (w_reg_addr != ZERO_REG_ADDR)) begin
         mem[w_reg_addr] <= w_reg_data;
      end
   end

   regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_rd_port1 (
      .rst_n      (rst_n),
      .r_en       (r1_en),
      .r_addr     (r1_addr),
      .w_reg_en   (w_reg_en),
      .w_reg_addr (w_reg_addr),
      .w_reg_data (w_reg_data),
      .mem        (mem),
      .r_data     (r1_data)
   );

   regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_rd_port2 (
      .rst_n      (rst_n),
      .r_en       (r2_en),
      .r_addr     (r2_addr),
      .w_reg_en   (w_reg_en),
      .w_reg_addr (w_reg_addr),
      .w_reg_data (w_reg_data),
      .mem        (mem),
      .r_data     (r2_data)
   );

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed literal checks plus random traffic against an array model.
module tb_regfile;

   logic        clk;
   logic        rst_n;
   logic        w_reg_en;
   logic [4:0]  w_reg_addr;
   logic [31:0] w_reg_data;
   logic        r1_en;
   logic [4:0]  r1_addr;
   logic [31:0] r1_data;
   logic        r2_en;
   logic [4:0]  r2_addr;
   logic [31:0] r2_data;

   int tests = 0;
   int fails = 0;
   logic [31:0] model [32];

   regfile u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .w_reg_en   (w_reg_en),
      .w_reg_addr (w_reg_addr),
      .w_reg_data (w_reg_data),
      .r1_en      (r1_en),
      .r1_addr    (r1_addr),
      .r1_data    (r1_data),
      .r2_en      (r2_en),
      .r2_addr    (r2_addr),
      .r2_data    (r2_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural state: cleared by reset, written on the edge unless target is $0.
   always @(negedge rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   end

   always @(posedge clk) begin
      if (rst_n && w_reg_en && (w_reg_addr != 5'd0)) model[w_reg_addr] = w_reg_data;
   end

   function automatic logic [31:0] expect_read(input logic en, input logic [4:0] addr);
      if (!rst_n || !en || addr == 5'd0) return 32'h0;
      if (w_reg_en && w_reg_addr == addr) return w_reg_data;
      return model[addr];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous compare against the model in the middle of every cycle.
   always @(negedge clk) begin
      check("model_r1", r1_data, expect_read(r1_en, r1_addr));
      check("model_r2", r2_data, expect_read(r2_en, r2_addr));
   end

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic e1, input logic [4:0] a1,
                        input logic e2, input logic [4:0] a2);
      @(posedge clk);
      #1;
      w_reg_en = we; w_reg_addr = wa; w_reg_data = wd;
      r1_en = e1; r1_addr = a1; r2_en = e2; r2_addr = a2;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      rst_n = 1'b0;
      w_reg_en = 1'b0; w_reg_addr = '0; w_reg_data = '0;
      r1_en = 1'b0; r1_addr = '0; r2_en = 1'b0; r2_addr = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Every register reads zero after reset
      for (int i = 1; i < 32; i++) begin
         drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(i));
         @(negedge clk);
         check("reset_r1", r1_data, 32'h0);
         check("reset_r2", r2_data, 32'h0);
      end

      // Basic write then read through storage
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
      drive(1'b1, 5'd31, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31);
      @(negedge clk);
      check("basic_r5", r1_data, 32'hDEADBEEF);
      check("basic_r31", r2_data, 32'h12345678);

      // $0 is never written and never bypassed
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd5);
      @(negedge clk);
      check("zero_same", r1_data, 32'h0);
      check("zero_other", r2_data, 32'hDEADBEEF);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0);
      @(negedge clk);
      check("zero_next", r1_data, 32'h0);

      // Write-first bypass on both ports
      drive(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0);
      drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 1'b1, 5'd7);
      @(negedge clk);
      check("bypass_r1", r1_data, 32'hA5A5A5A5);
      check("bypass_r2", r2_data, 32'hA5A5A5A5);
      drive(1'b0, 5'd7, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
      @(negedge clk);
      check("stored_r1", r1_data, 32'hA5A5A5A5);
      check("stored_r2", r2_data, 32'hA5A5A5A5);

      // Read enable gating
      drive(1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0, 1'b0, 5'd0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 1'b1, 5'd9);
      @(negedge clk);
      check("dis_r1", r1_data, 32'h0);
      check("en_r2", r2_data, 32'h00000099);

      // Asynchronous reset while a write is presented
      drive(1'b1, 5'd3, 32'hCAFE0000, 1'b0, 5'd0, 1'b0, 5'd0);
      drive(1'b1, 5'd4, 32'h00001111, 1'b1, 5'd3, 1'b1, 5'd4);
      #1;
      check("pre_rst_r3", r1_data, 32'hCAFE0000);
      check("pre_rst_byp", r2_data, 32'h00001111);
      rst_n = 1'b0;
      #1;
      check("rst_imm_r1", r1_data, 32'h0);
      check("rst_imm_r2", r2_data, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      w_reg_en = 1'b0;
      @(negedge clk);
      check("post_rst_r3", r1_data, 32'h0);
      check("post_rst_r4", r2_data, 32'h0);

      // Random traffic, with read addresses biased toward the write address
      for (int n = 0; n < 600; n++) begin
         logic [4:0] wa;
         logic [4:0] a1;
         logic [4:0] a2;
         wa = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 1)), wa, $urandom(),
               ($urandom_range(0, 7) != 0), a1, ($urandom_range(0, 7) != 0), a2);
         if ($urandom_range(0, 63) == 0) begin
            #2 rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
         end
      end

      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
